// File: rtl/pcpu_muldiv_pkg.sv
// rtl/pcpu_muldiv_pkg.sv - shared pcpu constants and muldiv state encoding
// Purpose: opcode constants used by the decoder, default datapath width and
//          the 2-bit state encoding of the iterative multiply/divide unit.
// Ports:   none (package).
package pcpu_muldiv_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [4:0] OP_MUL = 5'b10010;
  localparam logic [4:0] OP_DIV = 5'b10110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/pcpu_muldiv_if.sv
// rtl/pcpu_muldiv_if.sv - EX stage to multiply/divide unit handshake bundle
// Purpose: groups the request (start/op/flush/operands) and the response
//          (busy/done/result/remainder/ovf/dz) between EX and pcpu_muldiv.
// Ports:   master = EX side (drives request), slave = muldiv unit.
interface pcpu_muldiv_if
  import pcpu_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic             op;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             ovf;
  logic             dz;

  modport master (
    output start, op, flush, a, b,
    input  busy, done, result, remainder, ovf, dz
  );

  modport slave (
    input  start, op, flush, a, b,
    output busy, done, result, remainder, ovf, dz
  );

endinterface

// File: rtl/pcpu_muldiv.sv
// rtl/pcpu_muldiv.sv - iterative unsigned multiply/divide unit beside EX
// Purpose: shift-add multiply (LSB first) and restoring divide (MSB first),
//          one bit per clock, WIDTH iterations; busy stalls the pipeline,
//          done pulses for one cycle with the registered results.
// Ports:   clock  - rising-edge clock
//          reset  - asynchronous active-high reset
//          bus    - pcpu_muldiv_if.slave: start/op/flush/a/b in,
//                   busy/done/result/remainder/ovf/dz out
module pcpu_muldiv
  import pcpu_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input logic          clock,
  input logic          reset,
  pcpu_muldiv_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MUL: {partial product high, multiplier bits still to consume}
  // DIV: {partial remainder, dividend bits shifting into quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // MUL: multiplicand, DIV: divisor
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // One shift-add step: add multiplicand into the high half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  // The carry out of the add becomes the new MSB.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  // One restoring step: trial-subtract the divisor from the remainder
  // shifted left by one; bit WIDTH of the difference is the borrow.
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  logic               last_iter;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (div_trial[WIDTH]) begin
      div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    last_iter = (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        // flush beats start; a start in DONE chains with no bubble
        if (bus.start && !bus.flush) begin
          cnt_d = '0;
          if (!bus.op) begin
            state_d = ST_MUL;
            acc_d   = {{WIDTH{1'b0}}, bus.b};
            opnd_d  = bus.a;
          end else if (bus.b == '0) begin
            // divide by zero resolves at the start edge itself
            state_d  = ST_DONE;
            result_d = {WIDTH{1'b1}};
            rem_d    = bus.a;
            ovf_d    = 1'b0;
            dz_d     = 1'b1;
          end else begin
            state_d = ST_DIV;
            acc_d   = {{WIDTH{1'b0}}, bus.a};
            opnd_d  = bus.b;
          end
        end
      end

      ST_MUL: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            state_d  = ST_DONE;
            result_d = mul_next[WIDTH-1:0];
            ovf_d    = |mul_next[2*WIDTH-1:WIDTH];
            rem_d    = '0;
            dz_d     = 1'b0;
          end
        end
      end

      ST_DIV: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            state_d  = ST_DONE;
            result_d = div_next[WIDTH-1:0];
            rem_d    = div_next[2*WIDTH-1:WIDTH];
            ovf_d    = 1'b0;
            dz_d     = 1'b0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // busy/done are registered from the next state so they leave flops
    // directly rather than through decode logic.
    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.remainder = rem_q;
  assign bus.ovf       = ovf_q;
  assign bus.dz        = dz_q;

endmodule
